// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the M-extension sequencer: funct3 codes, FSM states and divider word layout.
package muldiv_seq_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } f3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] quot;
        logic [XLEN-1:0] rem;
    } div_word_t;

    function automatic logic [XLEN-1:0] div_pick(input div_word_t w, input logic rem_sel);
        return rem_sel ? w.rem : w.quot;
    endfunction

endpackage

// File: rtl/muldiv_seq_fixup.sv
// Resolves divide-by-zero and signed overflow without the divider core; shared with the ALU bypass.
module muldiv_seq_fixup
    import muldiv_seq_pkg::*;
(
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      f3_i,
    output logic            is_special_o,
    output logic [XLEN-1:0] special_result_o
);

    logic div_by_zero;
    logic signed_ovf;

    assign div_by_zero = (rs2_i == '0);
    assign signed_ovf  = ~f3_i[0] & (rs1_i == DIV_OVF_DIVIDEND) & (rs2_i == '1);

    assign is_special_o = f3_i[2] & (div_by_zero | signed_ovf);

    // x/0: quotient all ones, remainder x; MIN/-1: quotient MIN, remainder 0
    always_comb begin
        special_result_o = '0;
        if (div_by_zero) begin
            special_result_o = f3_i[1] ? rs1_i : '1;
        end else begin
            special_result_o = f3_i[1] ? '0 : DIV_OVF_DIVIDEND;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for the free-running multiplier/divider cores: operand latch, latency count,
// result capture, divide special cases, quotient/remainder reuse and EXE stall.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 20,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue,
    input  logic [2:0]          f3,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    input  logic                flush,
    input  logic [XLEN-1:0]     mul_lo,
    input  logic [XLEN-1:0]     mul_hss,
    input  logic [XLEN-1:0]     mul_hsu,
    input  logic [XLEN-1:0]     mul_huu,
    input  logic [2*XLEN-1:0]   div_s,
    input  logic [2*XLEN-1:0]   div_u,
    output logic [XLEN-1:0]     op_a,
    output logic [XLEN-1:0]     op_b,
    output logic                stall,
    output logic [XLEN-1:0]     result,
    output logic                done
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      f3_q, f3_d;
    logic            done_q, done_d;
    logic            reuse_v_q, reuse_v_d;
    logic            sgn_q, sgn_d;
    div_word_t       word_q, word_d;

    logic            is_special;
    logic [XLEN-1:0] special_result;
    logic            reuse_hit;
    logic            abort;
    div_word_t       core_word;
    logic [XLEN-1:0] mul_sel;

    muldiv_seq_fixup u_fixup (
        .rs1_i            (rs1),
        .rs2_i            (rs2),
        .f3_i             (f3),
        .is_special_o     (is_special),
        .special_result_o (special_result)
    );

    assign reuse_hit = f3[2] & reuse_v_q & (rs1 == op_a_q) & (rs2 == op_b_q) & (f3[0] == sgn_q);
    // A dropped issue during RUN is handled exactly like a flush
    assign abort     = flush | ((state_q == ST_RUN) & ~issue);
    assign stall     = ~rst & issue & ~flush & (state_q != ST_DONE);

    // Core output selection for the instruction latched in RUN
    always_comb begin
        core_word = f3_q[0] ? div_word_t'(div_u) : div_word_t'(div_s);
        mul_sel   = mul_lo;
        unique case (f3_q[1:0])
            2'b00:   mul_sel = mul_lo;
            2'b01:   mul_sel = mul_hss;
            2'b10:   mul_sel = mul_hsu;
            default: mul_sel = mul_huu;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        f3_d      = f3_q;
        result_d  = result_q;
        done_d    = 1'b0;
        reuse_v_d = reuse_v_q;
        sgn_d     = sgn_q;
        word_d    = word_q;

        unique case (state_q)
            ST_IDLE: begin
                if (issue && !flush) begin
                    if (reuse_hit) begin
                        result_d = div_pick(word_q, f3[1]);
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (is_special) begin
                        result_d  = special_result;
                        reuse_v_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        op_a_d  = rs1;
                        op_b_d  = rs2;
                        f3_d    = f3;
                        cnt_d   = f3[2] ? DIV_CNT : MUL_CNT;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    if (f3_q[2]) begin
                        result_d  = div_pick(core_word, f3_q[1]);
                        word_d    = core_word;
                        sgn_d     = f3_q[0];
                        reuse_v_d = 1'b1;
                    end else begin
                        result_d  = mul_sel;
                        reuse_v_d = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            result_d  = result_q;
            done_d    = 1'b0;
            reuse_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            f3_q      <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            reuse_v_q <= 1'b0;
            sgn_q     <= 1'b0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            f3_q      <= f3_d;
            result_q  <= result_d;
            done_q    <= done_d;
            reuse_v_q <= reuse_v_d;
            sgn_q     <= sgn_d;
            word_q    <= word_d;
        end
    end

    assign op_a   = op_a_q;
    assign op_b   = op_b_q;
    assign result = result_q;
    assign done   = done_q;

    a_issue_held: assert property (@(posedge clk) disable iff (rst)
        ((state_q == ST_RUN) && !flush) |-> issue);

    a_operands_stable: assert property (@(posedge clk) disable iff (rst)
        ((state_q == ST_RUN) && issue && !flush) |-> ((f3 == f3_q) && (rs1 == op_a_q) && (rs2 == op_b_q)));

endmodule
